// File: rtl/pcc_pkg.sv
// Shared constants and FSM state type for the PCC serial frame loader.
package pcc_pkg;

  localparam int unsigned POS_W_DEF = 2;
  localparam int unsigned NEG_W_DEF = 4;
  localparam int unsigned FRAME_W   = POS_W_DEF + NEG_W_DEF;
  localparam int unsigned IDX_W     = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    StFill,
    StHold,
    StFlush
  } pcc_state_e;

  // Keeps a usable index width even for one-bit frames.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/pcc_sat_cnt.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module pcc_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pcc_frame_loader.sv
// Deserialises binarized feature bits into positive/negative vectors, drops frames of
// wrong length and presents each good frame with a valid/ready handshake.
module pcc_frame_loader
  import pcc_pkg::*;
#(
  parameter int unsigned POS_W = POS_W_DEF,
  parameter int unsigned NEG_W = NEG_W_DEF,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic [POS_W-1:0] pos_vec,
  output logic [NEG_W-1:0] neg_vec,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             len_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned FW = POS_W + NEG_W;
  localparam int unsigned IW = idx_width(FW);

  pcc_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] buf_q, buf_d, frame_bits;
  logic          accept, at_end, load, len_err_d, err_inc, frame_inc;

  assign in_ready    = (state_q != StHold);
  assign frame_valid = (state_q == StHold);
  assign accept      = in_valid && in_ready;
  assign at_end      = (idx_q == IW'(FW - 1));
  assign frame_inc   = frame_valid && frame_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    load       = 1'b0;
    len_err_d  = 1'b0;
    err_inc    = 1'b0;
    // Assembly buffer with the current beat merged in, so the final bit loads directly.
    frame_bits         = buf_q;
    frame_bits[idx_q]  = in_bit;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          buf_d = frame_bits;
          if (at_end) begin
            idx_d = '0;
            if (in_last) begin
              state_d = StHold;
              load    = 1'b1;
            end else begin
              state_d   = StFlush;
              len_err_d = 1'b1;
              err_inc   = 1'b1;
            end
          end else if (in_last) begin
            idx_d     = '0;
            len_err_d = 1'b1;
            err_inc   = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      StHold: begin
        if (frame_ready) state_d = StFill;
      end
      StFlush: begin
        if (accept && in_last) begin
          state_d = StFill;
          idx_d   = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      idx_q   <= '0;
      buf_q   <= '0;
      pos_vec <= '0;
      neg_vec <= '0;
      len_err <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      len_err <= len_err_d;
      if (load) begin
        pos_vec <= frame_bits[POS_W-1:0];
        neg_vec <= frame_bits[FW-1:POS_W];
      end
    end
  end

  pcc_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (frame_inc),
    .cnt   (frame_cnt)
  );

  pcc_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (err_inc),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_pcc_frame_loader.sv
// Scoreboard bench for pcc_frame_loader; a second instance with 2-bit counters shares stimulus.
module tb_pcc_frame_loader;

  localparam int unsigned PW = 2;
  localparam int unsigned NW = 4;
  localparam int unsigned FW = PW + NW;

  typedef struct packed {
    logic [PW-1:0] pos;
    logic [NW-1:0] neg;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_bit, in_last, frame_ready;
  logic          in_ready, frame_valid, len_err;
  logic [PW-1:0] pos_vec;
  logic [NW-1:0] neg_vec;
  logic [7:0]    frame_cnt, err_cnt;
  logic          in_ready2, frame_valid2, len_err2;
  logic [PW-1:0] pos_vec2;
  logic [NW-1:0] neg_vec2;
  logic [1:0]    frame_cnt2, err_cnt2;

  int     n_checks = 0;
  int     n_fail = 0;
  int     len_pulses = 0;
  int     exp_pulses = 0;
  int     exp_frames = 0;
  int     exp_err = 0;
  frame_t sb[$];
  frame_t mon_f;

  always #5 clk = ~clk;

  pcc_frame_loader #(.POS_W(PW), .NEG_W(NW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
    .in_ready(in_ready), .pos_vec(pos_vec), .neg_vec(neg_vec), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .len_err(len_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  pcc_frame_loader #(.POS_W(PW), .NEG_W(NW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
    .in_ready(in_ready2), .pos_vec(pos_vec2), .neg_vec(neg_vec2), .frame_valid(frame_valid2),
    .frame_ready(frame_ready), .len_err(len_err2), .frame_cnt(frame_cnt2), .err_cnt(err_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && len_err) len_pulses++;
    if (rst_n && frame_valid && frame_ready) begin
      if (sb.size() == 0) begin
        check("unexpected frame", 32'd1, 32'd0);
      end else begin
        mon_f = sb.pop_front();
        check("pos_vec", 32'(pos_vec), 32'(mon_f.pos));
        check("neg_vec", 32'(neg_vec), 32'(mon_f.neg));
      end
    end
  end

  function automatic frame_t model(input logic [15:0] bits);
    frame_t f;
    f = '0;
    for (int k = 0; k < FW; k++) begin
      if (k < PW) f.pos[k] = bits[k];
      else        f.neg[k-PW] = bits[k];
    end
    return f;
  endfunction

  task automatic drive_beat(input logic b, input logic last);
    int waits;
    waits    = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) check("in_ready timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [15:0] bits, input int len, input bit gaps);
    logic good;
    good = (len == FW);
    if (good) sb.push_back(model(bits));
    for (int k = 0; k < len; k++) begin
      if (gaps && k > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      drive_beat(bits[k], k == len - 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("frame_valid latency", 32'(frame_valid), 32'(good));
    if (!good) begin
      exp_err++;
      exp_pulses++;
    end
    @(posedge clk); #1;
    if (good && frame_ready) begin
      exp_frames++;
      check("frame_valid width", 32'(frame_valid), 32'd0);
    end
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
    check("len_err pulses", 32'(len_pulses), 32'(exp_pulses));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t e;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    in_last     = 1'b0;
    frame_ready = 1'b1;
    #12;
    check("rst frame_valid", 32'(frame_valid), 32'd0);
    check("rst pos_vec", 32'(pos_vec), 32'd0);
    check("rst neg_vec", 32'(neg_vec), 32'd0);
    check("rst len_err", 32'(len_err), 32'd0);
    check("rst frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);

    // Reference stream 1,0,1,1,0,1
    send_frame(16'b10_1101, 6, 1'b0);
    check("ref pos_vec", 32'(pos_vec), 32'h1);
    check("ref neg_vec", 32'(neg_vec), 32'hB);

    send_frame(16'b101, 3, 1'b0);
    send_frame(16'b01_1010, 6, 1'b0);

    send_frame(16'b1111_1111, 8, 1'b0);
    send_frame(16'b11_0010, 6, 1'b0);

    // Back-pressure: downstream stalls while the source keeps offering bits.
    frame_ready = 1'b0;
    send_frame(16'b10_0110, 6, 1'b0);
    e        = model(16'b10_0110);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold frame_valid", 32'(frame_valid), 32'd1);
      check("hold pos_vec", 32'(pos_vec), 32'(e.pos));
      check("hold neg_vec", 32'(neg_vec), 32'(e.neg));
    end
    frame_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_frames++;
    check("hold frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("hold release", 32'(frame_valid), 32'd0);
    check("sat cnt mid", 32'(frame_cnt2), 32'd3);

    // Reset four bits into a frame.
    for (int k = 0; k < 4; k++) drive_beat(k[0], 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst pos_vec", 32'(pos_vec), 32'd0);
    check("async rst neg_vec", 32'(neg_vec), 32'd0);
    check("async rst frame_cnt", 32'(frame_cnt), 32'd0);
    check("async rst err_cnt", 32'(err_cnt), 32'd0);
    check("async rst frame_valid", 32'(frame_valid), 32'd0);
    check("async rst len_err", 32'(len_err), 32'd0);
    exp_frames = 0;
    exp_err    = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(16'b11_1001, 6, 1'b0);

    for (int n = 0; n < 5; n++) send_frame(16'($urandom_range(0, 63)), 6, 1'b1);
    check("sat frame_cnt", 32'(frame_cnt2), 32'd3);
    check("sat err_cnt", 32'(err_cnt2), 32'd0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
